// File: rtl/fp_class_pipe.sv
// Multi-lane IEEE-754 FCLASS classifier behind an elastic valid/ready pipe.
// Optional NaN-boxing check enabled by defining FP_CLASS_NANBOX_EN.
module fp_class_pipe #(
  parameter int NUM_LANES = 4,
  parameter int EXP_BITS  = 8,
  parameter int MAN_BITS  = 23,
  parameter int FLEN      = 32,
  parameter int TAG_WIDTH = 8,
  parameter int LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [TAG_WIDTH-1:0]      tag_in,
  input  logic [NUM_LANES*FLEN-1:0] dataa,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [TAG_WIDTH-1:0]      tag_out,
  output logic [NUM_LANES*32-1:0]   result,
  output logic [NUM_LANES*7-1:0]    clss,
  output logic [15:0]               nan_count
);

  localparam int W = 1 + EXP_BITS + MAN_BITS;
  localparam logic [FLEN-1:0] ONES = '1;

  logic [NUM_LANES*32-1:0] res_c;
  logic [NUM_LANES*7-1:0]  cls_c;
  logic [NUM_LANES-1:0]    nan_c;
  logic [NUM_LANES-1:0]    box_c;
  logic [FLEN-1:0]         op;
  logic [EXP_BITS-1:0]     ex;
  logic [MAN_BITS-1:0]     mn;
  logic                    sgn;
  logic                    e0;
  logic                    e1;
  logic                    m0;
  logic                    boxed;
  logic [6:0]              f;
  logic [9:0]              m;

  always_comb begin
    res_c = '0;
    cls_c = '0;
    nan_c = '0;
    box_c = '0;
    op = '0;
    ex = '0;
    mn = '0;
    sgn = 1'b0;
    e0 = 1'b0;
    e1 = 1'b0;
    m0 = 1'b0;
    boxed = 1'b0;
    f = '0;
    m = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      op = dataa[i*FLEN +: FLEN];
      sgn = op[W-1];
      ex = op[MAN_BITS +: EXP_BITS];
      mn = op[MAN_BITS-1:0];
      e0 = (ex == '0);
      e1 = (&ex);
      m0 = (mn == '0);
      // Upper bits of a wider register must be all ones for a valid box
      box_c[i] = (FLEN > W) && ((op >> W) != (ONES >> W));
`ifdef FP_CLASS_NANBOX_EN
      boxed = box_c[i];
`else
      boxed = 1'b0;
`endif
      if (boxed) begin
        f = 7'b0110000;
      end else begin
        f = {e1 & !m0 & !mn[MAN_BITS-1],
             e1 & !m0 & mn[MAN_BITS-1],
             e1 & !m0,
             e1 & m0,
             e0 & !m0,
             e0 & m0,
             !e0 & !e1};
      end
      m = '0;
      unique case (1'b1)
        f[6]: m[8] = 1'b1;
        f[5]: m[9] = 1'b1;
        f[3]: m[sgn ? 0 : 7] = 1'b1;
        f[2]: m[sgn ? 2 : 5] = 1'b1;
        f[1]: m[sgn ? 3 : 4] = 1'b1;
        f[0]: m[sgn ? 1 : 6] = 1'b1;
        default: m = '0;
      endcase
      res_c[i*32 +: 32] = {22'b0, m};
      cls_c[i*7 +: 7] = f;
      nan_c[i] = f[4];
    end
  end

`ifndef FP_CLASS_NANBOX_EN
  logic unused_box;
  assign unused_box = ^box_c;
`endif

  logic [LATENCY-1:0]      v;
  logic [LATENCY-1:0]      rdy;
  logic [TAG_WIDTH-1:0]    tg [LATENCY];
  logic [NUM_LANES*32-1:0] rs [LATENCY];
  logic [NUM_LANES*7-1:0]  cl [LATENCY];
  logic                    acc;
  logic [16:0]             nan_sum;
  logic [15:0]             nan_next;

  // A stage can load if it is empty or anything downstream can move
  always_comb begin
    acc = ready_out;
    rdy = '0;
    for (int s = LATENCY - 1; s >= 0; s--) begin
      acc = acc | !v[s];
      rdy[s] = acc;
    end
  end

  always_comb begin
    nan_sum = {1'b0, nan_count};
    for (int i = 0; i < NUM_LANES; i++) begin
      nan_sum = nan_sum + 17'(nan_c[i]);
    end
    nan_next = nan_sum[16] ? 16'hFFFF : nan_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v <= '0;
      nan_count <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        tg[s] <= '0;
        rs[s] <= '0;
        cl[s] <= '0;
      end
    end else begin
      if (rdy[0]) begin
        v[0] <= valid_in;
        if (valid_in) begin
          tg[0] <= tag_in;
          rs[0] <= res_c;
          cl[0] <= cls_c;
        end
      end
      for (int s = 1; s < LATENCY; s++) begin
        if (rdy[s]) begin
          v[s] <= v[s-1];
          if (v[s-1]) begin
            tg[s] <= tg[s-1];
            rs[s] <= rs[s-1];
            cl[s] <= cl[s-1];
          end
        end
      end
      if (valid_in && rdy[0]) begin
        nan_count <= nan_next;
      end
    end
  end

  assign ready_in  = rdy[0];
  assign valid_out = v[LATENCY-1];
  assign tag_out   = tg[LATENCY-1];
  assign result    = rs[LATENCY-1];
  assign clss      = cl[LATENCY-1];

endmodule
